// File: rtl/led_pwm_multi_pkg.sv
// Shared types for the multi-channel LED PWM controller: run modes, breath direction.
// Latency: none (types and constant helpers only).
// Backpressure: none.
package led_pwm_pkg;

   // Run-time mode as presented on the configuration bus.
   typedef enum logic [1:0] {
      MODE_OFF        = 2'd0,
      MODE_SCAN       = 2'd1,
      MODE_STATIC     = 2'd2,
      MODE_BREATH_ALL = 2'd3
   } mode_t;

   // Direction of the breath triangle.
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   // Width of a channel index; never below one bit so a single-LED build still has a port.
   function automatic int addr_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_pwm_multi_if.sv
// Configuration bus into the LED PWM controller: requested mode plus duty write strobe.
// Latency: none (wires only).
// Backpressure: none; writes are single-cycle strobes that are always accepted.
interface led_pwm_multi_if #(
   parameter int CHANNELS = 8,
   parameter int PWM_BITS = 7
);
   import led_pwm_pkg::*;

   localparam int AW = addr_bits(CHANNELS);

   logic [1:0]          mode;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [PWM_BITS-1:0] wr_data;

   modport master (output mode, output wr_en, output wr_addr, output wr_data);
   modport slave  (input  mode, input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/led_pwm_multi_breath.sv
// Breath generator: prescaler, triangle brightness level and scan channel index.
// Latency: lvl/ch_idx are registered and move on the tick edge; tick is combinational from the prescaler.
// Backpressure: none; free-running from reset.
module led_pwm_breath
   import led_pwm_pkg::*;
#(
   parameter  int CHANNELS = 8,
   parameter  int PWM_BITS = 7,
   parameter  int PRESCALE = 2097152,
   localparam int AW       = addr_bits(CHANNELS)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   output logic [PWM_BITS-1:0] o_lvl,
   output logic [AW-1:0]       o_ch_idx,
   output logic                o_tick
);

   localparam int                  PRE_W    = $clog2(PRESCALE);
   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
   localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);
   localparam logic [AW-1:0]       CH_LAST  = AW'(CHANNELS - 1);

   logic [PRE_W-1:0]    r_pre_cnt;
   logic [PWM_BITS-1:0] r_lvl;
   dir_t                r_dir;
   logic [AW-1:0]       r_ch_idx;
   logic                w_tick;
   logic                w_scan_step;

   assign w_tick = (r_pre_cnt == PRE_LAST);

   // The scan moves on exactly when the triangle steps from 1 down to 0.
   assign w_scan_step = w_tick && (r_dir == DIR_DOWN) && (r_lvl == LVL_ONE);

   // Prescaler: counts 0..PRESCALE-1 and wraps, tick marks the last count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pre_cnt <= '0;
      end else if (w_tick) begin
         r_pre_cnt <= '0;
      end else begin
         r_pre_cnt <= r_pre_cnt + 1'b1;
      end
   end

   // Triangle 0..MAX..0; the turning points are not repeated, so each end is held for one step only.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lvl <= '0;
         r_dir <= DIR_UP;
      end else if (w_tick) begin
         if (r_dir == DIR_UP) begin
            if (r_lvl == LVL_MAX) begin
               r_dir <= DIR_DOWN;
               r_lvl <= LVL_MAX - 1'b1;
            end else begin
               r_lvl <= r_lvl + 1'b1;
            end
         end else begin
            if (r_lvl == '0) begin
               r_dir <= DIR_UP;
               r_lvl <= LVL_ONE;
            end else begin
               r_lvl <= r_lvl - 1'b1;
            end
         end
      end
   end

   // Scan channel index, advanced once per breath cycle in every mode.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ch_idx <= '0;
      end else if (w_scan_step) begin
         r_ch_idx <= (r_ch_idx == CH_LAST) ? '0 : r_ch_idx + 1'b1;
      end
   end

   assign o_lvl    = r_lvl;
   assign o_ch_idx = r_ch_idx;
   assign o_tick   = w_tick;

endmodule

// File: rtl/led_pwm_multi.sv
// Multi-channel LED PWM: off / scanning breath / static duty / all-LED breath.
// Latency: LED is one cycle behind the PWM counter; mode and duty take effect at the next period boundary.
// Backpressure: none; duty writes are always accepted, out-of-range channels are dropped.
module led_pwm_multi
   import led_pwm_pkg::*;
#(
   parameter  int CHANNELS = 8,
   parameter  int PWM_BITS = 7,
   parameter  int PRESCALE = 2097152,
   localparam int AW       = addr_bits(CHANNELS)
) (
   input  logic                saatDarbesi,
   input  logic                reset,
   led_pwm_multi_if.slave      cfg_if,
   output logic [CHANNELS-1:0] LED,
   output logic [AW-1:0]       ch_idx,
   output logic                period_start
);

   localparam logic [PWM_BITS-1:0] CNT_LAST = '1;
   localparam logic [AW:0]         CH_LIMIT = (AW + 1)'(CHANNELS);

   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic                r_period_start;
   mode_t               r_mode_act;
   logic [PWM_BITS-1:0] r_shadow_duty [CHANNELS];
   logic [PWM_BITS-1:0] r_active_duty [CHANNELS];
   logic [CHANNELS-1:0] r_led;

   logic                w_boundary;
   logic                w_wr_ok;
   logic [CHANNELS-1:0] w_cmp;
   logic [PWM_BITS-1:0] w_lvl;
   logic [AW-1:0]       w_ch_idx;
   logic                w_unused_tick;

   assign w_boundary = (r_pwm_cnt == CNT_LAST);
   assign w_wr_ok    = cfg_if.wr_en && ({1'b0, cfg_if.wr_addr} < CH_LIMIT);

   led_pwm_breath #(
      .CHANNELS (CHANNELS),
      .PWM_BITS (PWM_BITS),
      .PRESCALE (PRESCALE)
   ) u_breath (
      .i_clk    (saatDarbesi),
      .i_rst    (reset),
      .o_lvl    (w_lvl),
      .o_ch_idx (w_ch_idx),
      .o_tick   (w_unused_tick)
   );

   // Free-running PWM counter; period_start flags the cycle after the wrap point.
   always_ff @(posedge saatDarbesi) begin
      if (reset) begin
         r_pwm_cnt      <= '0;
         r_period_start <= 1'b0;
      end else begin
         r_pwm_cnt      <= r_pwm_cnt + 1'b1;
         r_period_start <= w_boundary;
      end
   end

   // Requested mode is adopted only at a period boundary so no period is cut short.
   always_ff @(posedge saatDarbesi) begin
      if (reset) begin
         r_mode_act <= MODE_OFF;
      end else if (w_boundary) begin
         r_mode_act <= mode_t'(cfg_if.mode);
      end
   end

   // Shadow duty capture; a later write in the same period simply overwrites an earlier one.
   always_ff @(posedge saatDarbesi) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_shadow_duty[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_shadow_duty[cfg_if.wr_addr] <= cfg_if.wr_data;
      end
   end

   // Active duty copy at the boundary; a write landing on that same edge waits a full period.
   always_ff @(posedge saatDarbesi) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_active_duty[i] <= '0;
         end
      end else if (w_boundary) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_active_duty[i] <= r_shadow_duty[i];
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      logic [PWM_BITS-1:0] w_duty_eff;

      // Per-channel effective duty; breath level is used directly since its steps are slow.
      always_comb begin
         w_duty_eff = '0;
         case (r_mode_act)
            MODE_SCAN:       if (w_ch_idx == AW'(g)) w_duty_eff = w_lvl;
            MODE_STATIC:     w_duty_eff = r_active_duty[g];
            MODE_BREATH_ALL: w_duty_eff = w_lvl;
            default:         w_duty_eff = '0;
         endcase
      end

      assign w_cmp[g] = (r_pwm_cnt < w_duty_eff);
   end

   // Registered LED pins; duty MAX leaves one dark cycle per period by design.
   always_ff @(posedge saatDarbesi) begin
      if (reset) begin
         r_led <= '0;
      end else begin
         r_led <= w_cmp;
      end
   end

   assign LED          = r_led;
   assign ch_idx       = w_ch_idx;
   assign period_start = r_period_start;

endmodule

// File: tb/tb_led_pwm_multi.sv
// Directed bench for led_pwm_multi (CHANNELS=4/5, PWM_BITS=3, PRESCALE=4).
// Latency: expectations assume LED one cycle after pwm_cnt, lvl steps every 4 cycles.
// Backpressure: none exercised; writes are single-cycle strobes.
module tb_led_pwm_multi;
   import led_pwm_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   led_pwm_multi_if #(.CHANNELS(4), .PWM_BITS(3)) bus1 ();
   led_pwm_multi_if #(.CHANNELS(5), .PWM_BITS(3)) bus5 ();

   logic [3:0] led1;
   logic [1:0] ch1;
   logic       ps1;
   logic [4:0] led5;
   logic [2:0] ch5;
   logic       ps5;

   led_pwm_multi #(.CHANNELS(4), .PWM_BITS(3), .PRESCALE(4)) dut1 (
      .saatDarbesi  (clk),
      .reset        (rst),
      .cfg_if       (bus1.slave),
      .LED          (led1),
      .ch_idx       (ch1),
      .period_start (ps1)
   );

   led_pwm_multi #(.CHANNELS(5), .PWM_BITS(3), .PRESCALE(4)) dut5 (
      .saatDarbesi  (clk),
      .reset        (rst),
      .cfg_if       (bus5.slave),
      .LED          (led5),
      .ch_idx       (ch5),
      .period_start (ps5)
   );

   int errors = 0;
   int checks = 0;
   int n      = 0;
   int cnt1 [8][4];
   int cnt5 [5];
   int brc  [4];
   int bad;
   int exp_ch;
   logic [3:0] onehot;
   logic [2:0] lvl_seq [16] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (n=%0d)", tag, got, exp, n);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic wr1(input logic [1:0] a, input logic [2:0] d);
      bus1.wr_en   = 1'b1;
      bus1.wr_addr = a;
      bus1.wr_data = d;
   endtask

   task automatic wr5(input logic [2:0] a, input logic [2:0] d);
      bus5.wr_en   = 1'b1;
      bus5.wr_addr = a;
      bus5.wr_data = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset held 3 cycles with STATIC requested and a write strobe active.
      rst = 1'b1;
      bus1.mode = 2'd2; bus5.mode = 2'd2;
      wr1(2'd2, 3'd5);
      wr5(3'd4, 3'd5);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("rst_led", 32'(led1), 32'd0);
         check_eq("rst_ch", 32'(ch1), 32'd0);
         check_eq("rst_ps", 32'(ps1), 32'd0);
      end
      check_eq("rst_led5", 32'(led5), 32'd0);

      // Static duty, mid-period write, boundary write, last-write-wins, out-of-range.
      rst = 1'b0;
      n = 0;
      while (n < 48) begin
         bus1.wr_en = 1'b0;
         bus5.wr_en = 1'b0;
         case (n + 1)
            1:  begin wr1(2'd2, 3'd5); wr5(3'd5, 3'd7); end
            2:  begin wr1(2'd1, 3'd2); wr5(3'd7, 3'd7); end
            3:  wr5(3'd4, 3'd3);
            20: wr1(2'd1, 3'd6);
            32: wr1(2'd3, 3'd4);
            34: wr1(2'd0, 3'd1);
            36: wr1(2'd0, 3'd3);
            default: ;
         endcase
         step();
         if (n <= 16) check_eq("period_start", 32'(ps1), 32'(n % 8 == 0));
         if (n == 9)  check_eq("static_vec_9", 32'(led1), 32'b0110);
         if (n == 11) check_eq("static_vec_11", 32'(led1), 32'b0100);
         if (n == 14) check_eq("static_vec_14", 32'(led1), 32'b0000);
         if (n >= 9) begin
            for (int c = 0; c < 4; c++) cnt1[(n - 1) / 8][c] += int'(led1[c]);
            if (n <= 16) for (int c = 0; c < 5; c++) cnt5[c] += int'(led5[c]);
         end
      end
      bus1.wr_en = 1'b0;
      bus5.wr_en = 1'b0;
      check_eq("p1_ch0", cnt1[1][0], 0);
      check_eq("p1_ch1", cnt1[1][1], 2);
      check_eq("p1_ch2", cnt1[1][2], 5);
      check_eq("p1_ch3", cnt1[1][3], 0);
      check_eq("p2_ch1_old", cnt1[2][1], 2);
      check_eq("p3_ch1_new", cnt1[3][1], 6);
      check_eq("p4_ch3_bwr", cnt1[4][3], 0);
      check_eq("p4_ch0", cnt1[4][0], 0);
      check_eq("p5_ch3", cnt1[5][3], 4);
      check_eq("p5_ch0_last", cnt1[5][0], 3);
      check_eq("p5_ch2", cnt1[5][2], 5);
      check_eq("oor_ch0", cnt5[0], 0);
      check_eq("oor_ch1", cnt5[1], 0);
      check_eq("oor_ch2", cnt5[2], 0);
      check_eq("oor_ch3", cnt5[3], 0);
      check_eq("oor_ch4", cnt5[4], 3);

      // Reset mid-operation, then all-LED breath from a clean start.
      rst = 1'b1;
      bus1.mode = 2'd3;
      step();
      check_eq("rst2_led", 32'(led1), 32'd0);
      check_eq("rst2_ps", 32'(ps1), 32'd0);
      rst = 1'b0;
      n = 0;
      bad = 0;
      while (n < 77) begin
         step();
         if (n % 4 == 2 && n / 4 < 16) check_eq("breath_lvl", 32'(dut1.w_lvl), 32'(lvl_seq[n / 4]));
         if (n >= 9 && led1 != 4'h0 && led1 != 4'hF) bad++;
         if (n >= 9 && n <= 32) brc[(n - 1) / 8] += int'(led1[0]);
      end
      check_eq("breath_uniform", bad, 0);
      check_eq("breath_p1", brc[1], 2);
      check_eq("breath_p2", brc[2], 5);
      check_eq("breath_p3", brc[3], 7);
      check_eq("pre_rst_lvl", 32'(dut1.w_lvl), 32'd5);
      check_eq("pre_rst_dir", 32'(dut1.u_breath.r_dir), 32'(DIR_UP));

      // Reset at lvl=5 rising, then SCAN mode.
      rst = 1'b1;
      step();
      check_eq("rst3_lvl", 32'(dut1.w_lvl), 32'd0);
      check_eq("rst3_dir", 32'(dut1.u_breath.r_dir), 32'(DIR_UP));
      check_eq("rst3_mode", 32'(dut1.r_mode_act), 32'(MODE_OFF));
      check_eq("rst3_led", 32'(led1), 32'd0);
      check_eq("rst3_ch", 32'(ch1), 32'd0);
      rst = 1'b0;
      bus1.mode = 2'd1;
      n = 0;
      bad = 0;
      while (n < 230) begin
         step();
         exp_ch = (n < 56) ? 0 : (n < 112) ? 1 : (n < 168) ? 2 : (n < 224) ? 3 : 0;
         onehot = 4'b0001 << exp_ch;
         if ((led1 & ~onehot) != 4'b0000) bad++;
         if (n == 7)  check_eq("scan_ps_7", 32'(ps1), 32'd0);
         if (n == 8)  check_eq("scan_ps_8", 32'(ps1), 32'd1);
         if (n == 22) check_eq("scan_lvl_22", 32'(dut1.w_lvl), 32'd5);
         if (n == 9)  check_eq("scan_led_9", 32'(led1), 32'b0001);
         if (n == 65) check_eq("scan_led_65", 32'(led1), 32'b0010);
         if (n == 55 || n == 56 || n == 111 || n == 112 ||
             n == 167 || n == 168 || n == 223 || n == 224)
            check_eq("scan_ch_idx", 32'(ch1), 32'(exp_ch));
      end
      check_eq("scan_only_sel", bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
